booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Shares one N-bit Booth multiplier core between NREQ independent requesters. Accepts operand pairs over per-requester valid/ready handshakes, grants round-robin, sequences the core's start/done protocol, and returns the signed 2N-bit product tagged with the requester index. Sits between client logic and the multiplier top level, which it drives through its `mult_*` ports.

## Interface
- `N`, 4: operand width; product width is 2N.
- `NREQ`, 4: number of requesters (≥2).
- `TIMEOUT`, 4*N+8: WAIT-state cycle limit (used only with the macro).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  one-hot accept; at most one bit high.
- `req_a`  in  NREQ*N  multiplicand, requester i at bits [i*N +: N], signed.
- `req_b`  in  NREQ*N  multiplier, same packing, signed.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  clog2(NREQ)  index of the requester served.
- `rsp_data`  out  2N  signed product.
- `rsp_err`  out  1  timeout flag; tied 0 without the macro.
- `mult_start`  out  1  one-cycle start pulse to the core.
- `mult_a`, `mult_b`  out  N  operands to the core.
- `mult_data`  in  2N  core product.
- `mult_done`  in  1  core completion.
- `busy`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: the round-robin arbiter selects the first requester with `req_valid` high, searching from `ptr` upward with wrap. `req_ready` is high for that bit only (combinational from `req_valid` and `ptr`). On handshake: latch operands into `op_a`/`op_b`, latch id, set `ptr` = id+1 mod NREQ, go to ISSUE.
- ISSUE: `mult_start`=1 for exactly one cycle, then go to WAIT.
- WAIT: on the first cycle with `mult_done`=1, capture `mult_data` into `rsp_data` and go to RESP.
- RESP: `rsp_valid`=1. `rsp_id`, `rsp_data`, and `rsp_err` are held stable until `rsp_valid & rsp_ready`, then go to IDLE.
- `mult_a`/`mult_b` are driven from `op_a`/`op_b` continuously and stay stable from ISSUE through the end of WAIT.
- `req_ready` is all-zero outside IDLE. `req_valid` on a non-granted requester is not consumed and must be held by the client.
- `mult_done` is ignored in IDLE, ISSUE, and RESP. This covers stray completions from a core that has no reset of its own.
- The product is taken from the core unmodified, with no sign or width adjustment.

## Timing
- Reset values: state=IDLE, `ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `mult_start`=0, `mult_a`=`mult_b`=0, `busy`=0.
- Request handshake at cycle T → `mult_start` at T+1 → `mult_done` at T+1+L → `rsp_valid` at T+2+L.
- Back-to-back: RESP→IDLE takes one cycle, so the next accept happens no earlier than the cycle after the response handshake.
- Simultaneous requests resolve round-robin. No requester waits more than NREQ-1 grants.
- `rst` asserted in any state aborts the operation with no response. The core is not told, and its late `mult_done` is ignored.
- `rsp_ready` held low stalls the block indefinitely in RESP. No new request is accepted during the stall.

## Configuration
- `BOOTH_ARB_TIMEOUT_EN` defined:
  - A WAIT-cycle counter, cleared on entry to WAIT, runs while in WAIT.
  - If it reaches TIMEOUT without `mult_done`, the block goes to RESP with `rsp_data`=0 and `rsp_err`=1.
  - `rsp_err` clears on the next request accept.
- Macro undefined: no counter, WAIT is unbounded, and `rsp_err` is constant 0.

## Structure
- Shared package `booth_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - Id-width constant derived from NREQ.
  - Default TIMEOUT expression.
- Sub-module `rr_arbiter`:
  - Inputs: `req_valid` vector and `ptr`. Outputs: one-hot grant and encoded index.
  - Purely combinational. `ptr` is owned by `booth_mult_arbiter`.

## Test plan
- Single request, N=4, requester 2, a=3, b=5 → one `mult_start` pulse; `rsp_data`=8'h0F, `rsp_id`=2.
- Signed operands, a=4'hD (-3), b=5 → `rsp_data`=8'hF1 (-15); a=4'h8, b=4'h8 → 8'h40.
- All four requesters valid from reset and held → grant order 0,1,2,3,0. Each `req_ready` is one-hot, and `mult_a`/`mult_b` are stable through WAIT.
- `rsp_ready` low for 5 cycles in RESP → `rsp_valid`/`rsp_data`/`rsp_id` unchanged, `req_ready`=0; the response completes on the cycle `rsp_ready` rises.
- `rst` pulsed mid-WAIT, then a stray `mult_done` → all outputs at reset values, the stray `mult_done` is ignored, and the next request is served normally from `ptr`=0.
- With the macro, TIMEOUT=24 and `mult_done` never asserted → RESP entered 24 cycles after WAIT entry with `rsp_err`=1, `rsp_data`=0. Without the macro, `busy` stays high.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the Booth multiplier arbiter.
package booth_pkg;

  // Sequencer states: accept a request, pulse start, wait for the core, return the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_N    = 4;
  localparam int DEF_NREQ = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Default WAIT-state cycle limit: comfortably above a radix-2 Booth core's latency.
  function automatic int default_timeout(input int n);
    return 4 * n + 8;
  endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker. The search starts at
// ptr_i and wraps; the pointer itself is owned by the instantiating block.
module rr_arbiter
  import booth_pkg::*;
#(
  parameter int  NREQ = DEF_NREQ,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] grant_id_o,
  output logic            grant_valid_o
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest position back to ptr_i so the nearest valid requester wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would otherwise infer a latch.
    grant_o       = '0;
    grant_id_o    = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_i) + k) % NREQ);
      if (req_valid_i[idx]) begin
        grant_id_o    = idx;
        grant_valid_o = 1'b1;
      end
    end
    if (grant_valid_o) grant_o[grant_id_o] = 1'b1;
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: shares one N-bit Booth multiplier core between NREQ
// requesters, granting round-robin and returning the signed 2N-bit product
// tagged with the requester index.
// Optional feature: define BOOTH_ARB_TIMEOUT_EN to bound the WAIT state by
// TIMEOUT cycles; on expiry the response carries rsp_data=0 and rsp_err=1.
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int  N       = DEF_N,
  parameter int  NREQ    = DEF_NREQ,
  parameter int  TIMEOUT = default_timeout(N),
  localparam int ID_W    = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [2*N-1:0]    rsp_data,
  output logic              rsp_err,
  output logic              mult_start,
  output logic [N-1:0]      mult_a,
  output logic [N-1:0]      mult_b,
  input  logic [2*N-1:0]    mult_data,
  input  logic              mult_done,
  output logic              busy
);

  if (NREQ < 2 || N < 1 || TIMEOUT < 1) begin : g_param_check
    $error("booth_mult_arbiter: NREQ must be >= 2, N and TIMEOUT >= 1");
  end

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [N-1:0]    op_a_q, op_a_d;
  logic [N-1:0]    op_b_q, op_b_d;
  logic [2*N-1:0]  data_q, data_d;

  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic            grant_valid;
  logic            accept;
  logic            timeout_hit;
  logic [N-1:0]    sel_a, sel_b;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req_valid_i   (req_valid),
    .ptr_i         (ptr_q),
    .grant_o       (grant),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_valid)
  );

  // Offer the grant only while idle; held low during reset so nothing looks accepted.
  assign req_ready  = (state_q == IDLE && !rst) ? grant : '0;
  assign accept     = (state_q == IDLE) && !rst && grant_valid;

  assign mult_start = (state_q == ISSUE);
  assign mult_a     = op_a_q;
  assign mult_b     = op_b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign busy       = (state_q != IDLE);

  // One-hot operand mux driven by the arbiter grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
      end
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q;
  logic          err_q;

  assign timeout_hit = (tmr_q == TW'(TIMEOUT - 1));
  assign rsp_err     = err_q;

  // WAIT-cycle counter: held at zero outside WAIT so each WAIT entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tmr_q <= '0;
    else if (state_q == WAIT)   tmr_q <= tmr_q + 1'b1;
    else                        tmr_q <= '0;
  end

  // Timeout flag: set on expiry, held through the response, cleared by the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               err_q <= 1'b0;
    else if (accept)                                       err_q <= 1'b0;
    else if (state_q == WAIT && !mult_done && timeout_hit) err_q <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // Next-state and datapath updates; stray mult_done outside WAIT is ignored.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          id_d    = grant_id;
          ptr_d   = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mult_done) begin
          data_d  = mult_data;
          state_d = RESP;
        end else if (timeout_hit) begin
          data_d  = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values regardless of statement or process order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: scoreboard bench for booth_mult_arbiter with a
// behavioural multiplier core, directed scenarios and a randomized phase.
module tb_booth_mult_arbiter;
  import booth_pkg::*;

  localparam int N       = 4;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 24;
  localparam int ID_W    = id_width(NREQ);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [ID_W-1:0]   rsp_id;
  logic [2*N-1:0]    rsp_data;
  logic              rsp_err;
  logic              mult_start;
  logic [N-1:0]      mult_a, mult_b;
  logic [2*N-1:0]    mult_data = '0;
  logic              mult_done = 1'b0;
  logic              busy;

  booth_mult_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_data(mult_data), .mult_done(mult_done), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [2*N-1:0] data;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   m_ptr   = 0;
  int   start_due = -1;
  int   start_cyc = -1;
  int   done_cyc  = -1;
  int   start_cnt = 0;
  int   core_lat  = 0;
  bit   core_en   = 1'b1;
  bit   expect_timeout = 1'b0;
  int             last_id;
  logic [2*N-1:0] last_data;
  logic           last_err;

  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: signed product of two N-bit operands, truncated to 2N bits.
  function automatic logic [2*N-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return (2*N)'(sa * sb);
  endfunction

  // Reference: first valid requester at or after p, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Behavioural core: latches operands on start, answers after 1..6 cycles,
  // and presents noise on mult_data whenever done is low.
  initial begin
    int             cnt;
    logic [N-1:0]   ca, cb;
    cnt = -1;
    forever begin
      @(negedge clk);
      mult_done = 1'b0;
      mult_data = (2*N)'($urandom());
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mult_done = 1'b1;
          mult_data = smul(ca, cb);
          done_cyc  = cyc;
          cnt       = -1;
        end
      end
      #1;
      if (cnt > 0 && busy && !rst && !mult_start) begin
        check("mult_a_stable", mult_a, ca);
        check("mult_b_stable", mult_b, cb);
      end
      if (mult_start && core_en && !rst) begin
        ca  = mult_a;
        cb  = mult_b;
        cnt = (core_lat > 0) ? core_lat : int'($urandom_range(1, 6));
      end
    end
  end

  // Accept monitor: checks the grant against the round-robin model and pushes expectations.
  initial begin
    logic [NREQ-1:0] rdy, acc;
    int              gid, eid;
    bit              prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_start = 1'b0;
        continue;
      end
      rdy = req_ready;
      acc = rdy & req_valid;
      check("ready_onehot", 64'($countones(rdy) <= 1), 64'd1);
      check("ready_subset", rdy & ~req_valid, '0);
      if (busy) check("ready_zero_busy", rdy, '0);
      if (!busy && |req_valid) check("ready_when_idle", |rdy, 1'b1);
      if (|acc) begin
        gid = onehot_idx(acc);
        eid = rr_pick(req_valid, m_ptr);
        check("grant_id", gid, eid);
        grant_log.push_back(gid);
        sb_q.push_back('{id: gid,
                         data: expect_timeout ? '0 : smul(req_a[gid*N +: N], req_b[gid*N +: N]),
                         err: expect_timeout});
        m_ptr     = (eid + 1) % NREQ;
        start_due = cyc + 1;
      end
      if (mult_start) begin
        start_cnt++;
        check("start_timing", cyc, start_due);
        check("start_single", prev_start, 1'b0);
        start_cyc = cyc;
      end
      prev_start = mult_start;
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t e;
    bit   prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (rsp_valid && !prev_valid && sb_q.size() != 0) begin
        if (sb_q[0].err) check("rsp_timing_to", cyc, start_cyc + 1 + TIMEOUT);
        else             check("rsp_timing", cyc, done_cyc + 1);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id, rsp_data);
        end else begin
          e = sb_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", rsp_err, e.err);
          last_id   = int'(rsp_id);
          last_data = rsp_data;
          last_err  = rsp_err;
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_mult_start", mult_start, 1'b0);
    check("rst_mult_a", mult_a, '0);
    check("rst_mult_b", mult_b, '0);
    check("rst_busy", busy, 1'b0);
  endtask

  task automatic do_reset(input logic [NREQ-1:0] v);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = v;
    rsp_ready = 1'b0;
    sb_q.delete();
    m_ptr = 0;
    #4 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one request and hold it until accepted; returns at the ISSUE-cycle negedge.
  task automatic issue(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_valid[id]    = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #3;
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) fail_now("accept_wait");
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    while ((busy || sb_q.size() != 0) && c < budget) begin
      @(negedge clk);
      #3;
      c++;
    end
    if (c >= budget) fail_now("drain");
  endtask

  initial begin
    int              s0, c;
    int              exp_order[5];
    logic [2*N-1:0]  d0;
    logic [ID_W-1:0] i0;
    logic [NREQ-1:0] acc_prev;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state, then a single request from requester 2.
    do_reset('0);
    s0 = start_cnt;
    issue(2, 4'h3, 4'h5);
    drain(100);
    check("t1_data", last_data, 8'h0F);
    check("t1_id", last_id, 2);
    check("t1_starts", start_cnt - s0, 1);

    // Signed operands.
    issue(1, 4'hD, 4'h5);
    drain(100);
    check("t2_neg", last_data, 8'hF1);
    issue(3, 4'h8, 4'h8);
    drain(100);
    check("t2_minmin", last_data, 8'h40);

    // All four requesters valid from reset and held.
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = N'($urandom());
      req_b[i*N +: N] = N'($urandom());
    end
    grant_log.delete();
    do_reset('1);
    rsp_ready = 1'b1;
    c = 0;
    while (grant_log.size() < 5 && c < 300) begin
      @(negedge clk);
      #3;
      c++;
    end
    if (grant_log.size() < 5) fail_now("rr_wait");
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", grant_log[i], exp_order[i]);
    drain(200);

    // Response stall: outputs frozen, no accept, completion as rsp_ready rises.
    rsp_ready = 1'b0;
    issue(0, 4'h7, 4'h3);
    c = 0;
    while (!rsp_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!rsp_valid) fail_now("stall_wait");
    #3;
    d0 = rsp_data;
    i0 = rsp_id;
    check("stall_data", d0, 8'h15);
    check("stall_id", i0, 0);
    req_a[1*N +: N] = 4'h2;
    req_b[1*N +: N] = 4'h6;
    req_valid[1]    = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #3;
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_hold_data", rsp_data, d0);
      check("stall_hold_id", rsp_id, i0);
      check("stall_no_ready", req_ready, '0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #3 check("stall_last_cycle", rsp_valid, 1'b1);
    @(negedge clk);
    #3;
    check("stall_released", rsp_valid, 1'b0);
    check("stall_next_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    drain(200);

    // Reset mid-WAIT followed by a stray completion.
    core_lat = 6;
    issue(2, 4'h3, 4'h5);
    @(negedge clk);
    #3;
    rst = 1'b1;
    sb_q.delete();
    m_ptr = 0;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #3;
      check("stray_busy", busy, 1'b0);
      check("stray_rsp", rsp_valid, 1'b0);
    end
    core_lat = 0;
    @(negedge clk);
    req_a[1*N +: N] = 4'h4;
    req_b[1*N +: N] = 4'hF;
    req_a[3*N +: N] = 4'h1;
    req_b[3*N +: N] = 4'h1;
    req_valid = 4'b1010;
    #3 check("post_rst_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    drain(200);
    check("post_rst_data", last_data, 8'hFC);

    // Core that never completes.
    core_en = 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
    expect_timeout = 1'b1;
    issue(3, 4'h5, 4'h6);
    drain(200);
    check("to_err", last_err, 1'b1);
    check("to_data", last_data, '0);
    expect_timeout = 1'b0;
    core_en        = 1'b1;
    issue(0, 4'h2, 4'h3);
    drain(100);
    check("to_err_cleared", last_err, 1'b0);
`else
    issue(3, 4'h5, 4'h6);
    repeat (TIMEOUT + 20) begin
      @(negedge clk);
      #3;
      check("hang_busy", busy, 1'b1);
      check("hang_no_rsp", rsp_valid, 1'b0);
    end
    core_en = 1'b1;
    do_reset('0);
`endif

    // Randomized traffic with random back-pressure and core latency.
    acc_prev = '0;
    for (int c2 = 0; c2 < 600; c2++) begin
      @(negedge clk);
      req_valid = req_valid & ~acc_prev;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_a[i*N +: N] = N'($urandom());
          req_b[i*N +: N] = N'($urandom());
          req_valid[i]    = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #3 acc_prev = req_ready & req_valid;
    end
    @(negedge clk);
    req_valid = '0;
    drain(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
